// File: rtl/lsu.sv
// lsu - load/store unit placed directly after the execute stage.
//
// Takes one instruction at a time. Each instruction is one of:
//   - a non-memory op, whose execute result passes through unchanged
//   - a misaligned load/store, reported with o_misalign and no bus access
//   - an aligned load/store, which makes one 64-bit bus transaction
// The write-back value is then held on o_res until downstream accepts it.
//
// Ports:
//   i_clk, i_rst      clock; synchronous active-high reset
//   i_valid/o_ready   upstream handshake (o_ready is high only in IDLE)
//   i_exu_res         execute result (the address for loads/stores)
//   i_rs2             store data
//   i_lsu_opt         [4] unsigned, [3:2] kind (01 load, 10 store, other none),
//                     [1:0] size (B/H/W/D)
//   i_rd_idx/i_rd_wen destination register and write enable
//   o_mem_*           req/ack bus; outputs are stable while o_mem_req is high
//   i_mem_ack         one-cycle completion pulse, rdata valid with it
//   o_valid/i_ready   downstream handshake, payload held until accepted
//   o_res, o_rd_idx, o_rd_wen, o_misalign  write-back payload
//   o_dbg_state       current FSM state (0 IDLE, 1 MEM, 2 OUT)
//
// Handshake rule used on both sides: a transfer happens on a rising edge
// where valid and ready are both high. The sender holds valid and payload
// stable until that edge. Neither ready depends combinationally on valid.
module lsu #(
  parameter int DW = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_exu_res,
  input  logic [DW-1:0] i_rs2,
  input  logic [4:0]    i_lsu_opt,
  input  logic [4:0]    i_rd_idx,
  input  logic          i_rd_wen,
  output logic          o_mem_req,
  output logic          o_mem_wen,
  output logic [DW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic [7:0]    o_mem_wstrb,
  input  logic          i_mem_ack,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_res,
  output logic [4:0]    o_rd_idx,
  output logic          o_rd_wen,
  output logic          o_misalign,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Latched instruction fields.
  logic [DW-1:0] addr_q;
  logic [DW-1:0] rs2_q;
  logic [4:0]    opt_q;
  logic [4:0]    rd_idx_q;
  logic          rd_wen_q;
  logic [DW-1:0] res_q;
  logic          mis_q;

  // Decode of the incoming instruction (only used in IDLE).
  logic in_load, in_store, in_mem, in_mis;
  assign in_load  = (i_lsu_opt[3:2] == 2'b01);
  assign in_store = (i_lsu_opt[3:2] == 2'b10);
  assign in_mem   = in_load | in_store;

  always_comb begin
    in_mis = 1'b0;
    case (i_lsu_opt[1:0])
      2'd1:    in_mis = i_exu_res[0];
      2'd2:    in_mis = |i_exu_res[1:0];
      2'd3:    in_mis = |i_exu_res[2:0];
      default: in_mis = 1'b0;
    endcase
  end

  // Decode of the latched instruction.
  logic       q_store;
  logic [2:0] off_q;
  assign q_store = (opt_q[3:2] == 2'b10);
  assign off_q   = addr_q[2:0];

  // Load data: move the addressed byte lane down to bit 0, then extend.
  // Doublewords ignore the unsigned bit since there is nothing to extend.
  logic [DW-1:0] rdata_sh;
  logic [DW-1:0] load_ext;
  logic          sx;
  assign rdata_sh = i_mem_rdata >> {off_q, 3'b000};
  assign sx       = ~opt_q[4];

  always_comb begin
    load_ext = rdata_sh;
    case (opt_q[1:0])
      2'd0:    load_ext = {{(DW-8){sx & rdata_sh[7]}},   rdata_sh[7:0]};
      2'd1:    load_ext = {{(DW-16){sx & rdata_sh[15]}}, rdata_sh[15:0]};
      2'd2:    load_ext = {{(DW-32){sx & rdata_sh[31]}}, rdata_sh[31:0]};
      default: load_ext = rdata_sh;
    endcase
  end

  logic [7:0] strb_base;
  always_comb begin
    strb_base = 8'h00;
    case (opt_q[1:0])
      2'd0:    strb_base = 8'h01;
      2'd1:    strb_base = 8'h03;
      2'd2:    strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (i_valid) state_nxt = (in_mem && !in_mis) ? S_MEM : S_OUT;
      S_MEM:  if (i_mem_ack) state_nxt = S_OUT;
      S_OUT:  if (i_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Payload registers. The write enable is resolved at accept time so that
  // only the load data remains to be captured on ack.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q   <= '0;
      rs2_q    <= '0;
      opt_q    <= '0;
      rd_idx_q <= '0;
      rd_wen_q <= 1'b0;
      res_q    <= '0;
      mis_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            addr_q   <= i_exu_res;
            rs2_q    <= i_rs2;
            opt_q    <= i_lsu_opt;
            rd_idx_q <= i_rd_idx;
            mis_q    <= in_mem & in_mis;
            if (!in_mem) begin
              res_q    <= i_exu_res;
              rd_wen_q <= i_rd_wen;
            end else if (in_mis) begin
              res_q    <= i_exu_res;
              rd_wen_q <= 1'b0;
            end else begin
              res_q    <= '0;
              rd_wen_q <= in_load & i_rd_wen;
            end
          end
        end
        S_MEM: begin
          if (i_mem_ack) res_q <= q_store ? '0 : load_ext;
        end
        default: ;
      endcase
    end
  end

  // Bus outputs are forced to zero outside MEM so nothing stale is shown.
  logic in_mem_st;
  assign in_mem_st   = (state == S_MEM);
  assign o_mem_req   = in_mem_st;
  assign o_mem_wen   = in_mem_st & q_store;
  assign o_mem_addr  = in_mem_st ? {addr_q[DW-1:3], 3'b000} : '0;
  assign o_mem_wdata = (in_mem_st && q_store) ? (rs2_q << {off_q, 3'b000}) : '0;
  assign o_mem_wstrb = (in_mem_st && q_store) ? (strb_base << off_q) : 8'h00;

  assign o_ready     = (state == S_IDLE);
  assign o_valid     = (state == S_OUT);
  assign o_res       = res_q;
  assign o_rd_idx    = rd_idx_q;
  assign o_rd_wen    = rd_wen_q;
  assign o_misalign  = mis_q;
  assign o_dbg_state = state;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu - directed table-driven bench for lsu plus hand-written sequences
// for ack/ready stalls and reset during a bus transaction.
module tb_lsu;

  localparam int DW = 64;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_exu_res;
  logic [DW-1:0] i_rs2;
  logic [4:0]    i_lsu_opt;
  logic [4:0]    i_rd_idx;
  logic          i_rd_wen;
  logic          o_mem_req;
  logic          o_mem_wen;
  logic [DW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [7:0]    o_mem_wstrb;
  logic          i_mem_ack;
  logic [DW-1:0] i_mem_rdata;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_res;
  logic [4:0]    o_rd_idx;
  logic          o_rd_wen;
  logic          o_misalign;
  logic [1:0]    o_dbg_state;

  lsu #(.DW(DW)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_exu_res   (i_exu_res),
    .i_rs2       (i_rs2),
    .i_lsu_opt   (i_lsu_opt),
    .i_rd_idx    (i_rd_idx),
    .i_rd_wen    (i_rd_wen),
    .o_mem_req   (o_mem_req),
    .o_mem_wen   (o_mem_wen),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_wstrb (o_mem_wstrb),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_res       (o_res),
    .o_rd_idx    (o_rd_idx),
    .o_rd_wen    (o_rd_wen),
    .o_misalign  (o_misalign),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0]    opt;
    logic [DW-1:0] exu;
    logic [DW-1:0] rs2;
    logic [4:0]    rd;
    logic          wen;
    logic [DW-1:0] rdata;
    int            delay;
    logic          exp_mem;
    logic [DW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [7:0]    exp_wstrb;
    logic          exp_mwen;
    logic [DW-1:0] exp_res;
    logic          exp_rd_wen;
    logic          exp_mis;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic [4:0] opt, input logic [63:0] exu, input logic [63:0] rs2,
                         input logic [4:0] rd, input logic wen, input logic [63:0] rdata,
                         input int delay, input logic exp_mem, input logic [63:0] exp_addr,
                         input logic [63:0] exp_wdata, input logic [7:0] exp_wstrb,
                         input logic exp_mwen, input logic [63:0] exp_res,
                         input logic exp_rd_wen, input logic exp_mis);
    vec_t v;
    v.opt = opt; v.exu = exu; v.rs2 = rs2; v.rd = rd; v.wen = wen; v.rdata = rdata;
    v.delay = delay; v.exp_mem = exp_mem; v.exp_addr = exp_addr; v.exp_wdata = exp_wdata;
    v.exp_wstrb = exp_wstrb; v.exp_mwen = exp_mwen; v.exp_res = exp_res;
    v.exp_rd_wen = exp_rd_wen; v.exp_mis = exp_mis;
    vq.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_instr(input logic [4:0] opt, input logic [63:0] exu, input logic [63:0] rs2,
                             input logic [4:0] rd, input logic wen);
    i_valid   = 1'b1;
    i_lsu_opt = opt;
    i_exu_res = exu;
    i_rs2     = rs2;
    i_rd_idx  = rd;
    i_rd_wen  = wen;
  endtask

  // Runs one vector with i_ready held high; all sampling on falling edges.
  task automatic run_vec(input int idx, input vec_t v);
    logic [DW-1:0] exp_res;
    @(negedge i_clk);
    chk($sformatf("v%0d_ready_idle", idx), 64'(o_ready), 64'd1);
    drive_instr(v.opt, v.exu, v.rs2, v.rd, v.wen);
    exp_q.push_back(v.exp_res);
    @(negedge i_clk);
    i_valid = 1'b0;
    chk($sformatf("v%0d_ready_busy", idx), 64'(o_ready), 64'd0);
    if (v.exp_mem) begin
      chk($sformatf("v%0d_req", idx),   64'(o_mem_req), 64'd1);
      chk($sformatf("v%0d_addr", idx),  o_mem_addr, v.exp_addr);
      chk($sformatf("v%0d_wdata", idx), o_mem_wdata, v.exp_wdata);
      chk($sformatf("v%0d_wstrb", idx), 64'(o_mem_wstrb), 64'(v.exp_wstrb));
      chk($sformatf("v%0d_mwen", idx),  64'(o_mem_wen), 64'(v.exp_mwen));
      for (int d = 0; d < v.delay; d++) begin
        @(negedge i_clk);
        chk($sformatf("v%0d_req_hold", idx), 64'(o_mem_req), 64'd1);
      end
      i_mem_ack   = 1'b1;
      i_mem_rdata = v.rdata;
      @(negedge i_clk);
      i_mem_ack   = 1'b0;
      i_mem_rdata = '0;
    end
    chk($sformatf("v%0d_valid", idx),   64'(o_valid), 64'd1);
    chk($sformatf("v%0d_req_off", idx), 64'(o_mem_req), 64'd0);
    exp_res = exp_q.pop_front();
    chk($sformatf("v%0d_res", idx),     o_res, exp_res);
    chk($sformatf("v%0d_rd_idx", idx),  64'(o_rd_idx), 64'(v.rd));
    chk($sformatf("v%0d_rd_wen", idx),  64'(o_rd_wen), 64'(v.exp_rd_wen));
    chk($sformatf("v%0d_mis", idx),     64'(o_misalign), 64'(v.exp_mis));
    @(negedge i_clk);
    chk($sformatf("v%0d_valid_drop", idx), 64'(o_valid), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    // opt encoding: {unsigned, kind[1:0], size[1:0]}
    //       opt       exu                    rs2                    rd     wen   rdata                  dly mem addr                   wdata                  wstrb  mwen res                    rdw   mis
    add_vec(5'b00000, 64'h1234,              64'h0,                 5'd5,  1'b1, 64'h0,                 0, 0, 64'h0,                 64'h0,                 8'h00, 0, 64'h1234,              1'b1, 1'b0);
    add_vec(5'b01100, 64'hDEAD_BEEF,         64'h0,                 5'd7,  1'b1, 64'h0,                 0, 0, 64'h0,                 64'h0,                 8'h00, 0, 64'hDEAD_BEEF,         1'b1, 1'b0);
    add_vec(5'b00100, 64'h8000_0003,         64'h0,                 5'd1,  1'b1, 64'h0000_0000_80FF_0000, 0, 1, 64'h8000_0000,     64'h0,                 8'h00, 0, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0);
    add_vec(5'b10100, 64'h8000_0003,         64'h0,                 5'd2,  1'b1, 64'h0000_0000_80FF_0000, 1, 1, 64'h8000_0000,     64'h0,                 8'h00, 0, 64'h80,                1'b1, 1'b0);
    add_vec(5'b00110, 64'h4,                 64'h0,                 5'd3,  1'b1, 64'h8000_0001_0000_0000, 0, 1, 64'h0,             64'h0,                 8'h00, 0, 64'hFFFF_FFFF_8000_0001, 1'b1, 1'b0);
    add_vec(5'b10110, 64'h4,                 64'h0,                 5'd4,  1'b1, 64'h8000_0001_0000_0000, 2, 1, 64'h0,             64'h0,                 8'h00, 0, 64'h8000_0001,         1'b1, 1'b0);
    add_vec(5'b00101, 64'h2,                 64'h0,                 5'd6,  1'b1, 64'h0000_0000_8001_0000, 0, 1, 64'h0,             64'h0,                 8'h00, 0, 64'hFFFF_FFFF_FFFF_8001, 1'b1, 1'b0);
    add_vec(5'b10101, 64'h6,                 64'h0,                 5'd8,  1'b1, 64'hFFFE_0000_0000_0000, 0, 1, 64'h0,             64'h0,                 8'h00, 0, 64'hFFFE,              1'b1, 1'b0);
    add_vec(5'b10111, 64'h10,                64'h0,                 5'd9,  1'b1, 64'hFEDC_BA98_7654_3210, 0, 1, 64'h10,            64'h0,                 8'h00, 0, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
    add_vec(5'b00100, 64'h7,                 64'h0,                 5'd10, 1'b0, 64'h7F00_0000_0000_0000, 0, 1, 64'h0,             64'h0,                 8'h00, 0, 64'h7F,                1'b0, 1'b0);
    add_vec(5'b01001, 64'h1006,              64'hABCD,              5'd11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 64'h1000,          64'hABCD_0000_0000_0000, 8'hC0, 1, 64'h0,               1'b0, 1'b0);
    add_vec(5'b01000, 64'h2005,              64'h1122_3344_5566_77AA, 5'd12, 1'b1, 64'h0,               1, 1, 64'h2000,          64'h6677_AA00_0000_0000, 8'h20, 1, 64'h0,               1'b0, 1'b0);
    add_vec(5'b01011, 64'h3000,              64'h0123_4567_89AB_CDEF, 5'd13, 1'b1, 64'h0,               0, 1, 64'h3000,          64'h0123_4567_89AB_CDEF, 8'hFF, 1, 64'h0,               1'b0, 1'b0);
    add_vec(5'b01010, 64'h4,                 64'hCAFE_BABE,         5'd14, 1'b1, 64'h0,                 0, 1, 64'h0,             64'hCAFE_BABE_0000_0000, 8'hF0, 1, 64'h0,               1'b0, 1'b0);
    add_vec(5'b01010, 64'h1002,              64'h5555,              5'd15, 1'b1, 64'h0,                 0, 0, 64'h0,             64'h0,                 8'h00, 0, 64'h1002,              1'b0, 1'b1);
    add_vec(5'b00111, 64'h4,                 64'h0,                 5'd16, 1'b1, 64'h0,                 0, 0, 64'h0,             64'h0,                 8'h00, 0, 64'h4,                 1'b0, 1'b1);
    add_vec(5'b00101, 64'h1,                 64'h0,                 5'd17, 1'b1, 64'h0,                 0, 0, 64'h0,             64'h0,                 8'h00, 0, 64'h1,                 1'b0, 1'b1);

    // Reset: outputs all zero except o_ready.
    i_rst = 1'b1;
    i_valid = 1'b0; i_exu_res = '0; i_rs2 = '0; i_lsu_opt = '0; i_rd_idx = '0; i_rd_wen = 1'b0;
    i_mem_ack = 1'b0; i_mem_rdata = '0; i_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready",   64'(o_ready), 64'd1);
    chk("rst_valid",   64'(o_valid), 64'd0);
    chk("rst_req",     64'(o_mem_req), 64'd0);
    chk("rst_addr",    o_mem_addr, 64'd0);
    chk("rst_wstrb",   64'(o_mem_wstrb), 64'd0);
    chk("rst_res",     o_res, 64'd0);
    chk("rst_rd_wen",  64'(o_rd_wen), 64'd0);
    chk("rst_mis",     64'(o_misalign), 64'd0);
    chk("rst_state",   64'(o_dbg_state), 64'd0);
    i_rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) run_vec(i, vq[i]);

    // Stall sequence: LD with 5-cycle ack delay, then 3 cycles of i_ready=0,
    // with a pending i_valid that must wait until the handshake completes.
    @(negedge i_clk);
    drive_instr(5'b00111, 64'h40, 64'h0, 5'd9, 1'b1);
    @(negedge i_clk);
    drive_instr(5'b00000, 64'h55, 64'h0, 5'd3, 1'b1);
    for (int d = 0; d < 5; d++) begin
      chk("stall_req",   64'(o_mem_req), 64'd1);
      chk("stall_addr",  o_mem_addr, 64'h40);
      chk("stall_mwen",  64'(o_mem_wen), 64'd0);
      chk("stall_ready", 64'(o_ready), 64'd0);
      @(negedge i_clk);
    end
    i_mem_ack   = 1'b1;
    i_mem_rdata = 64'h1111_2222_3333_4444;
    i_ready     = 1'b0;
    @(negedge i_clk);
    i_mem_ack   = 1'b0;
    i_mem_rdata = '0;
    for (int s = 0; s < 3; s++) begin
      chk("hold_valid",  64'(o_valid), 64'd1);
      chk("hold_res",    o_res, 64'h1111_2222_3333_4444);
      chk("hold_rd_idx", 64'(o_rd_idx), 64'd9);
      chk("hold_rd_wen", 64'(o_rd_wen), 64'd1);
      chk("hold_ready",  64'(o_ready), 64'd0);
      if (s < 2) @(negedge i_clk);
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    chk("after_ack_ready", 64'(o_ready), 64'd1);
    chk("after_ack_valid", 64'(o_valid), 64'd0);
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("pend_valid",  64'(o_valid), 64'd1);
    chk("pend_res",    o_res, 64'h55);
    chk("pend_rd_idx", 64'(o_rd_idx), 64'd3);
    @(negedge i_clk);
    chk("pend_done", 64'(o_ready), 64'd1);

    // Reset during MEM, followed by a late ack that must be ignored.
    drive_instr(5'b00110, 64'h8, 64'h0, 5'd20, 1'b1);
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("rmem_req", 64'(o_mem_req), 64'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("rmem_req_drop", 64'(o_mem_req), 64'd0);
    chk("rmem_ready",    64'(o_ready), 64'd1);
    chk("rmem_valid",    64'(o_valid), 64'd0);
    i_mem_ack   = 1'b1;
    i_mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge i_clk);
    i_mem_ack   = 1'b0;
    i_mem_rdata = '0;
    chk("late_ack_valid", 64'(o_valid), 64'd0);
    chk("late_ack_ready", 64'(o_ready), 64'd1);
    @(negedge i_clk);
    chk("late_ack_valid2", 64'(o_valid), 64'd0);
    chk("late_ack_state",  64'(o_dbg_state), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the execute stage. It accepts the execute result as either a pass-through value or an effective address. It performs at most one 64-bit aligned memory transaction over a req/ack bus, then sign/zero-extends load data. It presents the write-back value to the next stage with a valid/ready handshake and holds each instruction until the handshake completes.

## Interface
Parameters:
- `DW`, 64: data/address width; must equal `CPU_WIDTH`.

Ports:
- `i_clk`  in  1  clock; one clock domain.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_valid`  in  1  upstream (execute) has an instruction.
- `o_ready`  out  1  LSU can accept; high only in IDLE.
- `i_exu_res`  in  DW  execute result; address for load/store.
- `i_rs2`  in  DW  store data.
- `i_lsu_opt`  in  5  [4] unsigned, [3:2] kind (00 none, 01 load, 10 store, 11 treated as none), [1:0] size (B/H/W/D).
- `i_rd_idx`  in  5  destination register.
- `i_rd_wen`  in  1  destination write enable.
- `o_mem_req`  out  1  bus request, held until ack.
- `o_mem_wen`  out  1  1 = store.
- `o_mem_addr`  out  DW  address with [2:0] forced to 0.
- `o_mem_wdata`  out  DW  store data shifted into byte lane.
- `o_mem_wstrb`  out  8  byte strobes, 0 for loads.
- `i_mem_ack`  in  1  one-cycle completion pulse.
- `i_mem_rdata`  in  DW  load data, valid with ack.
- `o_valid`  out  1  write-back result available.
- `i_ready`  in  1  downstream accepts.
- `o_res`  out  DW  write-back value.
- `o_rd_idx`  out  5  registered `i_rd_idx`.
- `o_rd_wen`  out  1  registered write enable, forced 0 for store/misaligned.
- `o_misalign`  out  1  access was misaligned; no bus access made.

## Operation
- FSM states: IDLE, MEM, OUT. Reset → IDLE.
- IDLE: `o_ready`=1. On `i_valid`, latch all inputs.
  - kind none → OUT, `o_res` = `i_exu_res`.
  - Misaligned load/store → OUT, `o_misalign`=1, `o_res` = address, `o_rd_wen`=0. Misaligned means H with addr[0]≠0, W with addr[1:0]≠0, D with addr[2:0]≠0.
  - Otherwise → MEM.
- MEM: `o_mem_req`=1. All bus outputs stable until ack. On `i_mem_ack` → OUT, capturing `i_mem_rdata`.
- OUT: `o_valid`=1; `o_res`/`o_rd_*` stable. On `i_ready` → IDLE.
- Address offset `off` = addr[2:0].
- Load data = `rdata >> (off*8)`, truncated to size. Sign-extended unless bit4=1; D ignores bit4.
- Store: `o_mem_wdata` = `rs2 << (off*8)`. `o_mem_wstrb` = ({1,3,F,FF}[size]) `<< off`. `o_res`=0, `o_rd_wen`=0.
- `i_mem_ack` outside MEM is ignored.
- `i_valid` outside IDLE is ignored, because `o_ready`=0.

## Timing
- Reset values of all outputs are 0, except `o_ready`=1 (IDLE).
- Reset mid-transaction: the next edge returns to IDLE and drops `o_mem_req`. The instruction is discarded and any late ack is ignored.
- Non-memory op: accepted at edge N, `o_valid` at N+1. Back-to-back throughput is one instruction per 2 cycles.
- Memory op: accepted at N, `o_mem_req` at N+1. Ack during cycle K gives `o_valid` at K+1. A same-cycle ack (K=N+1) is legal.
- `o_valid` is held with constant payload while `i_ready`=0, for any number of cycles.
- `o_ready` is a pure function of state; it has no combinational path from `i_ready` or `i_valid`.

## Test plan
- Pass-through: opt=none, exu_res=0x1234, rd=5, wen=1, i_ready=1. Expect `o_valid` one cycle later with `o_res`=0x1234, rd 5, wen 1, no `o_mem_req`.
- Signed/unsigned load: LB addr 0x8000_0003, rdata 0x0000_0000_80FF_0000 → `o_res`=0xFFFF_FFFF_FFFF_FF80. Same access as LBU → 0x80. LW addr 0x4, rdata 0x8000_0001_0000_0000 → 0xFFFF_FFFF_8000_0001.
- Store: SH addr 0x1006, rs2=0xABCD. Expect `o_mem_addr`=0x1000, wdata=0xABCD_0000_0000_0000, wstrb=0xC0, wen=1. After ack, `o_rd_wen`=0.
- Misaligned: SW addr 0x1002. Expect no `o_mem_req`, `o_valid` next cycle, `o_misalign`=1, `o_res`=0x1002.
- Stalls: delay ack 5 cycles, then hold `i_ready`=0 for 3 cycles. Bus outputs and result stay constant, `o_ready`=0 throughout, and a new `i_valid` is not accepted until after the `i_ready` cycle.
- Reset mid-MEM: assert `i_rst` while `o_mem_req`=1. Next cycle `o_mem_req`=0 and `o_ready`=1. A following ack produces no `o_valid`.
